// File: rtl/ddr_axi_arbiter.sv
// ddr_axi_arbiter: round-robin two-master arbiter sharing the simplified AXI4 port of ddr_sdram_ctrl
module ddr_axi_arbiter #(
    parameter int A_WIDTH = 26,
    parameter int D_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_awvalid,
    output logic               m0_awready,
    input  logic [A_WIDTH-1:0] m0_awaddr,
    input  logic [7:0]         m0_awlen,
    input  logic               m0_wvalid,
    output logic               m0_wready,
    input  logic               m0_wlast,
    input  logic [D_WIDTH-1:0] m0_wdata,
    output logic               m0_bvalid,
    input  logic               m0_bready,
    input  logic               m0_arvalid,
    output logic               m0_arready,
    input  logic [A_WIDTH-1:0] m0_araddr,
    input  logic [7:0]         m0_arlen,
    output logic               m0_rvalid,
    input  logic               m0_rready,
    output logic               m0_rlast,
    output logic [D_WIDTH-1:0] m0_rdata,
    input  logic               m1_awvalid,
    output logic               m1_awready,
    input  logic [A_WIDTH-1:0] m1_awaddr,
    input  logic [7:0]         m1_awlen,
    input  logic               m1_wvalid,
    output logic               m1_wready,
    input  logic               m1_wlast,
    input  logic [D_WIDTH-1:0] m1_wdata,
    output logic               m1_bvalid,
    input  logic               m1_bready,
    input  logic               m1_arvalid,
    output logic               m1_arready,
    input  logic [A_WIDTH-1:0] m1_araddr,
    input  logic [7:0]         m1_arlen,
    output logic               m1_rvalid,
    input  logic               m1_rready,
    output logic               m1_rlast,
    output logic [D_WIDTH-1:0] m1_rdata,
    output logic               s_awvalid,
    input  logic               s_awready,
    output logic [A_WIDTH-1:0] s_awaddr,
    output logic [7:0]         s_awlen,
    output logic               s_wvalid,
    input  logic               s_wready,
    output logic               s_wlast,
    output logic [D_WIDTH-1:0] s_wdata,
    input  logic               s_bvalid,
    output logic               s_bready,
    output logic               s_arvalid,
    input  logic               s_arready,
    output logic [A_WIDTH-1:0] s_araddr,
    output logic [7:0]         s_arlen,
    input  logic               s_rvalid,
    output logic               s_rready,
    input  logic               s_rlast,
    input  logic [D_WIDTH-1:0] s_rdata,
    output logic               grant_id,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

    state_t state;
    logic   last_grant;
    logic   req0, req1, win, win_aw;
    logic   in_waddr, in_wdata, in_wresp, in_raddr, in_rdata;

    // arbitration: a lone requester wins, a tie goes to the master not served last
    always_comb begin
        req0   = m0_awvalid | m0_arvalid;
        req1   = m1_awvalid | m1_arvalid;
        win    = (req0 & req1) ? ~last_grant : req1;
        win_aw = win ? m1_awvalid : m0_awvalid;
    end

    assign in_waddr = (state == WADDR);
    assign in_wdata = (state == WDATA);
    assign in_wresp = (state == WRESP);
    assign in_raddr = (state == RADDR);
    assign in_rdata = (state == RDATA);
    assign busy     = (state != IDLE);

    assign s_awvalid = in_waddr & (grant_id ? m1_awvalid : m0_awvalid);
    assign s_awaddr  = grant_id ? m1_awaddr : m0_awaddr;
    assign s_awlen   = grant_id ? m1_awlen : m0_awlen;
    assign s_wvalid  = in_wdata & (grant_id ? m1_wvalid : m0_wvalid);
    assign s_wlast   = grant_id ? m1_wlast : m0_wlast;
    assign s_wdata   = grant_id ? m1_wdata : m0_wdata;
    assign s_bready  = in_wresp & (grant_id ? m1_bready : m0_bready);
    assign s_arvalid = in_raddr & (grant_id ? m1_arvalid : m0_arvalid);
    assign s_araddr  = grant_id ? m1_araddr : m0_araddr;
    assign s_arlen   = grant_id ? m1_arlen : m0_arlen;
    assign s_rready  = in_rdata & (grant_id ? m1_rready : m0_rready);

    assign m0_awready = ~grant_id & in_waddr & s_awready;
    assign m0_wready  = ~grant_id & in_wdata & s_wready;
    assign m0_bvalid  = ~grant_id & in_wresp & s_bvalid;
    assign m0_arready = ~grant_id & in_raddr & s_arready;
    assign m0_rvalid  = ~grant_id & in_rdata & s_rvalid;
    assign m0_rlast   = ~grant_id & in_rdata & s_rlast;
    assign m0_rdata   = s_rdata;

    assign m1_awready = grant_id & in_waddr & s_awready;
    assign m1_wready  = grant_id & in_wdata & s_wready;
    assign m1_bvalid  = grant_id & in_wresp & s_bvalid;
    assign m1_arready = grant_id & in_raddr & s_arready;
    assign m1_rvalid  = grant_id & in_rdata & s_rvalid;
    assign m1_rlast   = grant_id & in_rdata & s_rlast;
    assign m1_rdata   = s_rdata;

    // transaction sequencing: one whole burst owns the controller, writes preferred over reads
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    grant_id <= win;
                    state    <= win_aw ? WADDR : RADDR;
                end
                WADDR: if (s_awvalid & s_awready) state <= WDATA;
                WDATA: if (s_wvalid & s_wready & s_wlast) state <= WRESP;
                WRESP: if (s_bvalid & s_bready) begin
                    state      <= IDLE;
                    last_grant <= grant_id;
                end
                RADDR: if (s_arvalid & s_arready) state <= RDATA;
                RDATA: if (s_rvalid & s_rready & s_rlast) begin
                    state      <= IDLE;
                    last_grant <= grant_id;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// tb_ddr_axi_arbiter: directed scoreboard bench with master agents and a controller model
module tb_ddr_axi_arbiter;
    localparam int A = 26;
    localparam int D = 16;

    typedef struct packed { logic [A-1:0] addr; logic [7:0] len; } ax_t;
    typedef struct packed { logic [D-1:0] data; logic last; } beat_t;
    typedef struct packed { logic g; logic wr; logic [A-1:0] addr; logic [7:0] len; } tx_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [A-1:0] m_awaddr [2];
    logic [A-1:0] m_araddr [2];
    logic [7:0] m_awlen [2];
    logic [7:0] m_arlen [2];
    logic [D-1:0] m_wdata [2];
    logic [D-1:0] m_rdata [2];
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [A-1:0] s_awaddr, s_araddr;
    logic [7:0] s_awlen, s_arlen;
    logic [D-1:0] s_wdata, s_rdata;
    logic grant_id, busy;

    int checks = 0;
    int errors = 0;

    ax_t   awq [2][$];
    ax_t   arq [2][$];
    beat_t wdq [2][$];
    beat_t rexp [2][$];
    tx_t   sb_tx [$];
    beat_t sb_w [$];
    int    bcnt [2];
    int    rcnt [2];
    logic [1:0] rready_en;
    logic  force_b;
    int    cyc = 0;
    int    rl_cyc0 = -100;
    int    ar_cyc1 = -200;

    always #5 clk = ~clk;

    ddr_axi_arbiter #(.A_WIDTH(A), .D_WIDTH(D)) dut (
        .clk(clk), .rst(rst),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wlast(m_wlast[0]), .m0_wdata(m_wdata[0]),
        .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rlast(m_rlast[0]), .m0_rdata(m_rdata[0]),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wlast(m_wlast[1]), .m1_wdata(m_wdata[1]),
        .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rlast(m_rlast[1]), .m1_rdata(m_rdata[1]),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rdata(s_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int cnt(input int w);
        return (w < 2) ? bcnt[w] : rcnt[w-2];
    endfunction

    task automatic wait_cnt(input string tag, input int w, input int target);
        int k = 0;
        while (cnt(w) < target && k < 400) begin
            step();
            k++;
        end
        chk(tag, 32'(cnt(w)), 32'(target));
    endtask

    task automatic push_wr(input int n, input logic [A-1:0] a, input logic [7:0] l, input logic [D-1:0] d0);
        beat_t b;
        awq[n].push_back('{addr: a, len: l});
        for (int i = 0; i <= int'(l); i++) begin
            b = '{data: d0 + D'(i), last: (i == int'(l))};
            wdq[n].push_back(b);
            sb_w.push_back(b);
        end
        sb_tx.push_back('{g: 1'(n), wr: 1'b1, addr: a, len: l});
    endtask

    task automatic push_rd(input int n, input logic [A-1:0] a, input logic [7:0] l);
        arq[n].push_back('{addr: a, len: l});
        for (int i = 0; i <= int'(l); i++)
            rexp[n].push_back('{data: a[D-1:0] + D'(i), last: (i == int'(l))});
        sb_tx.push_back('{g: 1'(n), wr: 1'b0, addr: a, len: l});
    endtask

    // master agents and controller model: sample just before the edge, update just after it
    initial begin
        logic [1:0] aw_f, w_f, b_f, ar_f, r_f;
        logic saw_f, sw_f, sb_f, sar_f, sr_f, rst_s, wl_s;
        logic [D-1:0] rbase = '0;
        logic [7:0] rlen = '0;
        int rd_left = 0;
        int ridx = 0;
        logic b_pend = 1'b0;
        tx_t t;
        beat_t b;
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '1; m_arvalid = '0; m_rready = '1;
        for (int n = 0; n < 2; n++) begin
            m_awaddr[n] = '0; m_awlen[n] = '0; m_araddr[n] = '0; m_arlen[n] = '0; m_wdata[n] = '0;
            bcnt[n] = 0; rcnt[n] = 0;
        end
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
        s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
        forever begin
            @(negedge clk);
            #2;
            rst_s = rst;
            aw_f = m_awvalid & m_awready; w_f = m_wvalid & m_wready; b_f = m_bvalid & m_bready;
            ar_f = m_arvalid & m_arready; r_f = m_rvalid & m_rready;
            saw_f = s_awvalid & s_awready; sw_f = s_wvalid & s_wready; sb_f = s_bvalid & s_bready;
            sar_f = s_arvalid & s_arready; sr_f = s_rvalid & s_rready; wl_s = s_wlast;
            if (saw_f || sar_f) begin
                if (sb_tx.size() == 0) chk("tx_unexpected", 32'(1), 32'(0));
                else begin
                    t = sb_tx.pop_front();
                    chk("tx_grant", 32'(grant_id), 32'(t.g));
                    chk("tx_is_write", 32'(saw_f), 32'(t.wr));
                    chk("tx_addr", 32'(saw_f ? s_awaddr : s_araddr), 32'(t.addr));
                    chk("tx_len", 32'(saw_f ? s_awlen : s_arlen), 32'(t.len));
                end
            end
            if (sw_f) begin
                if (sb_w.size() == 0) chk("w_unexpected", 32'(1), 32'(0));
                else begin
                    b = sb_w.pop_front();
                    chk("w_data", 32'(s_wdata), 32'(b.data));
                    chk("w_last", 32'(s_wlast), 32'(b.last));
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (r_f[n]) begin
                    if (rexp[n].size() == 0) chk($sformatf("r_unexpected_m%0d", n), 32'(1), 32'(0));
                    else begin
                        b = rexp[n].pop_front();
                        chk($sformatf("r_data_m%0d", n), 32'(m_rdata[n]), 32'(b.data));
                        chk($sformatf("r_last_m%0d", n), 32'(m_rlast[n]), 32'(b.last));
                    end
                end
                if (b_f[n]) chk($sformatf("b_while_busy_m%0d", n), 32'(busy), 32'(1));
                if (!busy || grant_id != 1'(n))
                    chk($sformatf("quiet_m%0d", n),
                        32'({m_awready[n], m_wready[n], m_bvalid[n], m_arready[n], m_rvalid[n], m_rlast[n]}), 32'(0));
            end
            if (!busy) chk("quiet_s", 32'({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 32'(0));
            if (sr_f && s_rlast && grant_id == 1'b0) rl_cyc0 = cyc;
            if (sar_f && grant_id == 1'b1) ar_cyc1 = cyc;
            if (sar_f) begin
                rbase = s_araddr[D-1:0];
                rlen = s_arlen;
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int n = 0; n < 2; n++) begin
                if (b_f[n]) bcnt[n]++;
                if (r_f[n]) rcnt[n]++;
            end
            if (rst_s) begin
                for (int n = 0; n < 2; n++) begin
                    awq[n].delete(); arq[n].delete(); wdq[n].delete(); rexp[n].delete();
                end
                sb_tx.delete(); sb_w.delete();
                rd_left = 0; ridx = 0; b_pend = 1'b0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (aw_f[n]) void'(awq[n].pop_front());
                    if (w_f[n]) void'(wdq[n].pop_front());
                    if (ar_f[n]) void'(arq[n].pop_front());
                end
                if (sar_f) begin
                    rd_left = int'(rlen) + 1;
                    ridx = 0;
                end
                if (sr_f) begin
                    ridx++;
                    rd_left--;
                end
                if (sw_f && wl_s) b_pend = 1'b1;
                if (sb_f) b_pend = 1'b0;
            end
            for (int n = 0; n < 2; n++) begin
                m_awvalid[n] = awq[n].size() != 0;
                if (m_awvalid[n]) begin m_awaddr[n] = awq[n][0].addr; m_awlen[n] = awq[n][0].len; end
                m_wvalid[n] = wdq[n].size() != 0;
                if (m_wvalid[n]) begin m_wdata[n] = wdq[n][0].data; m_wlast[n] = wdq[n][0].last; end
                else m_wlast[n] = 1'b0;
                m_arvalid[n] = arq[n].size() != 0;
                if (m_arvalid[n]) begin m_araddr[n] = arq[n][0].addr; m_arlen[n] = arq[n][0].len; end
                m_rready[n] = rready_en[n];
            end
            s_rvalid = rd_left != 0;
            s_rlast = rd_left == 1;
            s_rdata = rbase + D'(ridx);
            s_bvalid = b_pend | force_b;
        end
    end

    // directed sequence
    initial begin
        int held;
        rst = 1'b1;
        force_b = 1'b0;
        rready_en = 2'b11;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_grant", 32'(grant_id), 32'(0));
        chk("reset_quiet", 32'({m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                                s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 32'(0));
        rst = 1'b0;
        step();

        push_rd(0, 26'h200, 8'd7);
        push_rd(1, 26'h300, 8'd7);
        wait_cnt("tie_m0_reads", 2, 8);
        wait_cnt("tie_m1_reads", 3, 8);
        chk("tie_bubble", 32'(ar_cyc1 - rl_cyc0), 32'(2));

        push_wr(0, 26'h1000, 8'd1, 16'h0100);
        push_wr(1, 26'h2000, 8'd2, 16'h0200);
        push_wr(0, 26'h1100, 8'd0, 16'h0110);
        push_wr(1, 26'h2100, 8'd3, 16'h0210);
        wait_cnt("rr_m0_writes", 0, 2);
        wait_cnt("rr_m1_writes", 1, 2);

        push_wr(0, 26'h100, 8'd7, 16'h0000);
        wait_cnt("wr_m0_b", 0, 3);
        chk("wr_busy_fall", 32'(busy), 32'(0));
        chk("wr_no_b_m1", 32'(bcnt[1]), 32'(2));

        push_wr(1, 26'h3000, 8'd3, 16'h0300);
        push_rd(1, 26'h3400, 8'd7);
        wait_cnt("wa_write_b", 1, 3);
        wait_cnt("wa_first_beats", 3, 11);
        rready_en[1] = 1'b0;
        step();
        held = rcnt[1];
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_s_rready", 32'(s_rready), 32'(0));
        end
        chk("hold_no_beats", 32'(rcnt[1]), 32'(held));
        rready_en[1] = 1'b1;
        wait_cnt("wa_all_beats", 3, 16);
        step();
        chk("wa_rexp_empty", 32'(rexp[1].size()), 32'(0));

        force_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stray_b_bready", 32'(s_bready), 32'(0));
            chk("stray_b_idle", 32'(busy), 32'(0));
        end
        force_b = 1'b0;
        repeat (2) step();
        chk("stray_b_no_resp", 32'(bcnt[0] + bcnt[1]), 32'(6));

        push_rd(0, 26'h400, 8'd7);
        wait_cnt("mid_rd_beats", 2, 11);
        rst = 1'b1;
        step();
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_grant", 32'(grant_id), 32'(0));
        chk("mid_rst_quiet", 32'({m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                                  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 32'(0));
        rst = 1'b0;
        step();
        push_rd(1, 26'h500, 8'd3);
        repeat (2) step();
        chk("post_rst_busy", 32'(busy), 32'(1));
        chk("post_rst_grant", 32'(grant_id), 32'(1));
        wait_cnt("post_rst_beats", 3, 20);
        step();
        chk("end_tx_empty", 32'(sb_tx.size()), 32'(0));
        chk("end_w_empty", 32'(sb_w.size()), 32'(0));
        chk("end_r_empty", 32'(rexp[0].size() + rexp[1].size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
